md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits (legal 8..64, even).
REQ-002 Parameter: CNT_W, default 6, iteration counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: start_i  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-006 Port: annul_i  input  1  abort the operation in progress.
REQ-007 Port: op_div_i  input  1  0 = multiply, 1 = divide.
REQ-008 Port: signed_i  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 Port: opdata1_i  input  WIDTH  multiplicand or dividend.
REQ-010 Port: opdata2_i  input  WIDTH  multiplier or divisor.
REQ-011 Port: busy_o  output  1  high in CALC and SIGN; stage stall request.
REQ-012 Port: ready_o  output  1  high only in DONE; result valid.
REQ-013 Port: result_o  output  2*WIDTH  {hi, lo}; mul: full product; div: {remainder, quotient}.

Function
REQ-014 FSM states: IDLE, CALC, SIGN, DONE; busy_o and ready_o decoded from state only.
REQ-015 IDLE/DONE with start_i=1, annul_i=0, divisor nonzero or op mul: capture op_div_i, signed_i, operands, operand sign bits; counter=0; go CALC.
REQ-016 Operands SHALL be converted to magnitudes at capture when signed_i=1; inputs not re-sampled afterwards.
REQ-017 CALC: one iteration per cycle, exactly WIDTH cycles, counter 0..WIDTH-1; go SIGN when counter=WIDTH-1.
REQ-018 Multiply: radix-2 shift-add on magnitudes, 2*WIDTH-bit accumulator, no truncation.
REQ-019 Divide: radix-2 restoring; per cycle shift remainder:quotient left 1, subtract divisor if remainder >= divisor (WIDTH+1-bit compare), set quotient bit.
REQ-020 SIGN (1 cycle): signed mul negates 2*WIDTH product if operand signs differ; signed div negates quotient if signs differ, remainder takes dividend sign; result register loaded; go DONE.
REQ-021 Signed MIN / -1: quotient = MIN (wrap), remainder = 0; no flag.
REQ-022 Divide by zero: IDLE/DONE with start_i=1, op_div_i=1, opdata2_i=0 goes directly to DONE, result_o = {opdata1_i, all ones}, no CALC.
REQ-023 Latency: start sampled at edge 0 -> ready_o high during cycle after edge WIDTH+1 (divide by zero: after edge 0).
REQ-024 DONE lasts one cycle; returns to IDLE, or goes CALC (or DONE for div-by-zero) if start_i=1 (back-to-back allowed).
REQ-025 result_o SHALL hold its value from DONE until the next SIGN or div-by-zero load, independent of state.
REQ-026 start_i in CALC or SIGN ignored.
REQ-027 annul_i=1 in any state: next state IDLE, no ready_o pulse, result_o unchanged; annul_i wins over simultaneous start_i.

Reset
REQ-028 rst=1 asynchronously forces IDLE, counter 0, busy_o=0, ready_o=0, result_o=0, all datapath registers 0.
REQ-029 rst asserted mid-CALC abandons the operation; no ready_o after release; first start after release behaves per REQ-015.

Verification
REQ-030 WIDTH=32, unsigned div 100/7 -> busy_o 33 cycles, ready_o after edge 33, result_o = {2, 14}.
REQ-031 signed div -7/2 -> {hi=-1 (0xFFFFFFFF), lo=-3 (0xFFFFFFFD)}; signed 0x80000000/-1 -> {0, 0x80000000}.
REQ-032 signed mul -3*5 -> 0xFFFFFFFF_FFFFFFF1; unsigned 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE_00000001.
REQ-033 div 9/0 -> ready_o after edge 0, busy_o never high, result_o = {9, 0xFFFFFFFF}.
REQ-034 annul_i at CALC cycle 10 -> IDLE next edge, no ready_o, result_o keeps prior value; start in DONE chains second op with ready_o 34 edges later.
REQ-035 rst pulse mid-CALC -> outputs zero immediately (asynchronous), then fresh mul 6*7 -> {0, 42}.

Source files
------------

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module  : md_unit
// Brief   : Iterative radix-2 multiplier / restoring divider, signed/unsigned.
// Rev     : 1.0
// ============================================================================
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               op_div_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op_div;
  logic               r_neg;
  logic               r_rem_neg;
  logic [WIDTH-1:0]   r_op1;
  logic [WIDTH-1:0]   r_op2;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept, w_dbz, w_go, w_last;
  logic               w_s1, w_s2;
  logic [WIDTH-1:0]   w_mag1, w_mag2;
  logic [WIDTH:0]     w_mul_sum, w_div_rem;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod_fix;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && start_i && !annul_i;
  assign w_dbz    = w_accept && op_div_i && (opdata2_i == '0);
  assign w_go     = w_accept && !w_dbz;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_s1   = signed_i & opdata1_i[WIDTH-1];
  assign w_s2   = signed_i & opdata2_i[WIDTH-1];
  assign w_mag1 = w_s1 ? -opdata1_i : opdata1_i;
  assign w_mag2 = w_s2 ? -opdata2_i : opdata2_i;

  // Multiply: acc = {hi, lo}; lo starts as multiplier and is shifted out LSB first
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_op1} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, quotient}; the shifted remainder needs WIDTH+1 bits
  assign w_div_rem  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge   = (w_div_rem >= {1'b0, r_op2});
  assign w_div_diff = w_div_rem[WIDTH-1:0] - r_op2;
  assign w_div_next = {(w_div_ge ? w_div_diff : w_div_rem[WIDTH-1:0]), r_acc[WIDTH-2:0], w_div_ge};

  assign w_prod_fix = r_neg ? -r_acc : r_acc;
  assign w_quo      = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem      = r_rem_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (annul_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_dbz)     w_next = S_DONE;
          else if (w_go) w_next = S_CALC;
          else           w_next = S_IDLE;
        end
        S_CALC:  if (w_last) w_next = S_SIGN;
        S_SIGN:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Annul freezes the datapath so the last delivered result stays visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_op_div  <= 1'b0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_acc     <= '0;
      r_result  <= '0;
    end else if (!annul_i) begin
      if (w_dbz) begin
        r_result <= {opdata1_i, {WIDTH{1'b1}}};
      end else if (w_go) begin
        r_op_div  <= op_div_i;
        r_neg     <= w_s1 ^ w_s2;
        r_rem_neg <= w_s1;
        r_op1     <= w_mag1;
        r_op2     <= w_mag2;
        r_acc     <= {{WIDTH{1'b0}}, (op_div_i ? w_mag1 : w_mag2)};
        r_cnt     <= '0;
      end else if (r_state == S_CALC) begin
        r_acc <= r_op_div ? w_div_next : w_mul_next;
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_SIGN) begin
        r_result <= r_op_div ? {w_rem, w_quo} : w_prod_fix;
      end
    end
  end

  assign busy_o   = (r_state == S_CALC) || (r_state == S_SIGN);
  assign ready_o  = (r_state == S_DONE);
  assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_md_unit
// Brief   : Directed self-checking bench for md_unit (WIDTH=32).
// Rev     : 1.0
// ============================================================================
module tb_md_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_i = 1'b0;
  logic           annul_i = 1'b0;
  logic           op_div_i = 1'b0;
  logic           signed_i = 1'b0;
  logic [W-1:0]   opdata1_i = '0;
  logic [W-1:0]   opdata2_i = '0;
  logic           busy_o;
  logic           ready_o;
  logic [2*W-1:0] result_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .op_div_i  (op_div_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .result_o  (result_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic div, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    op_div_i  = div;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  // Edges after the start edge until ready_o, bounded at 100
  task automatic wait_ready(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!ready_o && n < 100) begin
      if (busy_o) nbusy++;
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic div, input logic sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp, input int lat, input int nb);
    int n, nbo;
    launch(div, sgn, a, b);
    wait_ready(n, nbo);
    check({tag, "_lat"},  64'(n),   64'(lat));
    check({tag, "_busy"}, 64'(nbo), 64'(nb));
    check({tag, "_res"},  result_o, exp);
    tick();
    check({tag, "_rdy1"}, {63'b0, ready_o}, 64'd0);
  endtask

  initial begin
    int n, nbo, rdy_cnt;
    logic [63:0] prev;

    tick();
    tick();
    check("rst_busy",   {63'b0, busy_o},  64'd0);
    check("rst_ready",  {63'b0, ready_o}, 64'd0);
    check("rst_result", result_o,         64'd0);
    rst = 1'b0;

    run_op("udiv_100_7",  1'b1, 1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 33, 33);
    run_op("sdiv_m7_2",   1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33, 33);
    run_op("sdiv_7_m2",   1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 33);
    run_op("sdiv_min_m1", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, 33);
    run_op("smul_m3_5",   1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 33, 33);
    run_op("umul_max",    1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 33, 33);
    run_op("smul_m4_m6",  1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFA, 64'h00000000_00000018, 33, 33);
    run_op("udiv_9_0",    1'b1, 1'b0, 32'd9,        32'd0,        64'h00000009_FFFFFFFF, 0, 0);

    // start together with annul in IDLE must be dropped
    op_div_i = 1'b0;
    start_i  = 1'b1;
    annul_i  = 1'b1;
    tick();
    start_i  = 1'b0;
    annul_i  = 1'b0;
    check("annul_vs_start", {62'b0, busy_o, ready_o}, 64'd0);

    // annul mid-CALC: back to IDLE, no ready, result untouched
    prev = result_o;
    launch(1'b1, 1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) tick();
    check("annul_busy_pre", {63'b0, busy_o}, 64'd1);
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    check("annul_idle", {62'b0, busy_o, ready_o}, 64'd0);
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) rdy_cnt++;
      tick();
    end
    check("annul_no_ready", 64'(rdy_cnt), 64'd0);
    check("annul_result",   result_o,     prev);

    // back-to-back: second start sampled in DONE
    launch(1'b0, 1'b0, 32'h12345678, 32'h00000010);
    wait_ready(n, nbo);
    check("b2b_op1_res", result_o, 64'h00000001_23456780);
    op_div_i  = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd10;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    wait_ready(n, nbo);
    check("b2b_op2_lat", 64'(n + 1), 64'd34);
    check("b2b_op2_res", result_o, 64'h00000000_00000064);

    // asynchronous reset mid-CALC
    launch(1'b0, 1'b0, 32'd123, 32'd456);
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy",   {63'b0, busy_o},  64'd0);
    check("arst_ready",  {63'b0, ready_o}, 64'd0);
    check("arst_result", result_o,         64'd0);
    tick();
    rst = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o || busy_o) rdy_cnt++;
      tick();
    end
    check("arst_quiet", 64'(rdy_cnt), 64'd0);
    run_op("umul_6_7", 1'b0, 1'b0, 32'd6, 32'd7, 64'h00000000_0000002A, 33, 33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
